// File: rtl/audio_mix_pkg.sv
// Shared channel mode encodings, config FSM states and arithmetic helpers
// for the TX-path audio mixer/modulator.
package audio_mix_pkg;

  localparam logic [1:0] MODE_MUTE   = 2'b00;
  localparam logic [1:0] MODE_DIRECT = 2'b01;
  localparam logic [1:0] MODE_INV    = 2'b10;
  localparam logic [1:0] MODE_DSB    = 2'b11;

  typedef enum logic {CFG_READY, CFG_PENDING} cfg_state_t;

  function automatic int UNITY_GAIN(input int gain_w);
    return 1 << (gain_w - 1);
  endfunction

  // Clamp a sign-extended value into the w-bit two's complement range.
  function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/mix_chan_stage.sv
// One channel's mode select and gain multiply; 1 cycle latency (registered on en).
// No backpressure: a new sample may be accepted every cycle.
module mix_chan_stage
  import audio_mix_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int GAIN_W = 8
) (
  input  logic              clk_in,
  input  logic              RST,
  input  logic              en,
  input  logic [DATA_W-1:0] x,
  input  logic [1:0]        mode,
  input  logic [GAIN_W-1:0] gain,
  input  logic              nco_msb,
  output logic [DATA_W:0]   p
);

  localparam int VW = DATA_W + 1;
  localparam int PW = DATA_W + GAIN_W + 2;

  logic signed [VW-1:0] xe;
  logic signed [VW-1:0] v;
  logic signed [PW-1:0] prod;

  // Negation happens at DATA_W+1 bits so the most negative input inverts exactly.
  always_comb begin
    xe = VW'($signed(x));
    v  = '0;
    case (mode)
      MODE_MUTE:   v = '0;
      MODE_DIRECT: v = xe;
      MODE_INV:    v = -xe;
      MODE_DSB:    v = nco_msb ? -xe : xe;
      default:     v = '0;
    endcase
    prod = PW'(v) * $signed(PW'({1'b0, gain}));
  end

  always_ff @(posedge clk_in) begin
    if (RST)     p <= '0;
    else if (en) p <= VW'(prod >>> (GAIN_W - 1));
  end

endmodule

// File: rtl/audio_mix_mod.sv
// N-channel mixer with saturating sum (3-cycle sample latency) and FM carrier word (2-cycle latency).
// Audio path never stalls; config uses valid/ready with one pending request committed on a sample boundary.
module audio_mix_mod
  import audio_mix_pkg::*;
#(
  parameter int     N_CH       = 2,
  parameter int     DATA_W     = 12,
  parameter int     GAIN_W     = 8,
  parameter int     PHASE_W    = 32,
  parameter longint CARRIER_FW = 416611827,
  parameter longint FM_SENS    = 10486,
  parameter longint SUB_FW     = 858993
) (
  input  logic                   clk_in,
  input  logic                   RST,
  input  logic                   sample_valid,
  input  logic [N_CH*DATA_W-1:0] audio_in,
  input  logic [DATA_W-1:0]      fm_sig,
  input  logic                   fm_en,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [2:0]             cfg_ch,
  input  logic [1:0]             cfg_mode,
  input  logic [GAIN_W-1:0]      cfg_gain,
  output logic                   cfg_err,
  output logic [DATA_W-1:0]      mix_out,
  output logic                   mix_valid,
  output logic [PHASE_W-1:0]     fre_word,
  input  logic                   clip_clr,
  output logic [15:0]            clip_cnt
);

  localparam int VW    = DATA_W + 1;
  localparam int SUM_W = DATA_W + 1 + $clog2(N_CH);

  logic [PHASE_W-1:0]  nco_phase;
  logic [1:0]          mode_r [N_CH];
  logic [GAIN_W-1:0]   gain_r [N_CH];
  cfg_state_t          cfg_state;
  logic [2:0]          pend_ch;
  logic [1:0]          pend_mode;
  logic [GAIN_W-1:0]   pend_gain;
  logic                commit;
  logic [VW-1:0]       p_arr [N_CH];
  logic                v1, v2;
  logic signed [SUM_W-1:0] sum_c, sum_r;
  logic signed [31:0]  sum_ext, sat_v;
  logic                clip;
  logic [PHASE_W-1:0]  fm_t;

  assign commit = (cfg_state == CFG_PENDING) && sample_valid;

  // The committing sample already sees the new setting; the stored copy catches up on the same edge.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic              hit;
    logic [1:0]        eff_mode;
    logic [GAIN_W-1:0] eff_gain;
    assign hit      = commit && (pend_ch == 3'(k));
    assign eff_mode = hit ? pend_mode : mode_r[k];
    assign eff_gain = hit ? pend_gain : gain_r[k];

    mix_chan_stage #(.DATA_W(DATA_W), .GAIN_W(GAIN_W)) u_chan (
      .clk_in  (clk_in),
      .RST     (RST),
      .en      (sample_valid),
      .x       (audio_in[k*DATA_W +: DATA_W]),
      .mode    (eff_mode),
      .gain    (eff_gain),
      .nco_msb (nco_phase[PHASE_W-1]),
      .p       (p_arr[k])
    );
  end

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < N_CH; k++) sum_c = sum_c + SUM_W'($signed(p_arr[k]));
  end

  assign sum_ext = 32'(sum_r);
  assign sat_v   = sat(sum_ext, DATA_W);
  assign clip    = (sat_v != sum_ext);

  always_ff @(posedge clk_in) begin
    if (RST) nco_phase <= '0;
    else     nco_phase <= nco_phase + PHASE_W'(SUB_FW);
  end

  always_ff @(posedge clk_in) begin
    if (RST) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      sum_r     <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      clip_cnt  <= '0;
    end else begin
      v1        <= sample_valid;
      v2        <= v1;
      mix_valid <= v2;
      if (v1) sum_r   <= sum_c;
      if (v2) mix_out <= DATA_W'(sat_v);
      if (clip_clr)
        clip_cnt <= '0;
      else if (v2 && clip && clip_cnt != 16'hFFFF)
        clip_cnt <= clip_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (RST) begin
      fm_t     <= '0;
      fre_word <= PHASE_W'(CARRIER_FW);
    end else begin
      if (sample_valid) fm_t     <= PHASE_W'($signed(fm_sig)) * PHASE_W'(FM_SENS);
      if (v1)           fre_word <= PHASE_W'(CARRIER_FW) + (fm_en ? fm_t : '0);
    end
  end

  always_ff @(posedge clk_in) begin
    if (RST) begin
      cfg_state <= CFG_READY;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      pend_ch   <= '0;
      pend_mode <= '0;
      pend_gain <= '0;
      for (int k = 0; k < N_CH; k++) begin
        mode_r[k] <= MODE_DIRECT;
        gain_r[k] <= GAIN_W'(UNITY_GAIN(GAIN_W));
      end
    end else begin
      cfg_err <= 1'b0;
      case (cfg_state)
        CFG_READY: begin
          if (cfg_valid) begin
            if (int'(cfg_ch) >= N_CH) begin
              cfg_err <= 1'b1;
            end else begin
              pend_ch   <= cfg_ch;
              pend_mode <= cfg_mode;
              pend_gain <= cfg_gain;
              cfg_state <= CFG_PENDING;
              cfg_ready <= 1'b0;
            end
          end
        end
        CFG_PENDING: begin
          if (sample_valid) begin
            for (int k = 0; k < N_CH; k++) begin
              if (pend_ch == 3'(k)) begin
                mode_r[k] <= pend_mode;
                gain_r[k] <= pend_gain;
              end
            end
            cfg_state <= CFG_READY;
            cfg_ready <= 1'b1;
          end
        end
        default: cfg_state <= CFG_READY;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_mix_mod.sv
// Self-checking bench for audio_mix_mod (N_CH=2, default parameters):
// directed tables, hand sequences and a randomized run against a behavioural model.
module tb_audio_mix_mod;

  localparam longint CARRIER = 416611827;
  localparam longint SENS    = 10486;
  localparam longint SUBW    = 858993;

  logic        clk_in = 1'b0;
  logic        RST = 1'b1;
  logic        sample_valid = 1'b0;
  logic [23:0] audio_in = '0;
  logic [11:0] fm_sig = '0;
  logic        fm_en = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [2:0]  cfg_ch = '0;
  logic [1:0]  cfg_mode = '0;
  logic [7:0]  cfg_gain = '0;
  logic        cfg_err;
  logic [11:0] mix_out;
  logic        mix_valid;
  logic [31:0] fre_word;
  logic        clip_clr = 1'b0;
  logic [15:0] clip_cnt;

  audio_mix_mod dut (
    .clk_in(clk_in), .RST(RST), .sample_valid(sample_valid), .audio_in(audio_in),
    .fm_sig(fm_sig), .fm_en(fm_en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_gain(cfg_gain), .cfg_err(cfg_err),
    .mix_out(mix_out), .mix_valid(mix_valid), .fre_word(fre_word),
    .clip_clr(clip_clr), .clip_cnt(clip_cnt)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural reference model ----------------
  typedef struct { longint due; int mix; bit clipped; } exp_t;
  exp_t   exp_q[$];
  int     obs_q[$];
  longint edge_idx = 0;
  longint nco_n = 0;
  int     m_mode [2];
  int     m_gain [2];
  bit     m_pend, m_rdy;
  int     p_ch, p_mode, p_gain;
  bit     fm_pend;
  longint fm_t;
  logic [31:0] exp_fre;
  int     exp_clip;
  bit     exp_rdy, exp_err;
  bit     mon_en = 1'b0;

  function automatic int chan(input int x, input int mode, input int g, input bit msb);
    int v;
    longint q;
    case (mode)
      0:       v = 0;
      1:       v = x;
      2:       v = -x;
      default: v = msb ? -x : x;
    endcase
    q = longint'(v) * g;
    if (q >= 0) return int'(q / 128);
    else        return int'(-((-q + 127) / 128));
  endfunction

  initial forever begin
    int  s, c;
    bit  msb;
    exp_t e;
    @(posedge clk_in);
    edge_idx++;
    if (RST) begin
      nco_n = 0; exp_q.delete(); m_pend = 0; fm_pend = 0; fm_t = 0;
      exp_fre = 32'(CARRIER); exp_clip = 0; exp_rdy = 1; exp_err = 0;
      for (int k = 0; k < 2; k++) begin m_mode[k] = 1; m_gain[k] = 128; end
    end else begin
      m_rdy = !m_pend;
      msb = (((nco_n * SUBW) >> 31) & 1) != 0;
      if (clip_clr) exp_clip = 0;
      else if (exp_q.size() > 0 && exp_q[0].due == edge_idx && exp_q[0].clipped && exp_clip < 65535)
        exp_clip++;
      if (fm_pend) exp_fre = 32'(CARRIER + (fm_en ? fm_t : 0));
      fm_pend = sample_valid;
      if (sample_valid) begin
        fm_t = longint'($signed(fm_sig)) * SENS;
        if (m_pend) begin
          m_mode[p_ch] = p_mode; m_gain[p_ch] = p_gain; m_pend = 0;
        end
        s = chan(int'($signed(audio_in[11:0])), m_mode[0], m_gain[0], msb)
          + chan(int'($signed(audio_in[23:12])), m_mode[1], m_gain[1], msb);
        c = (s > 2047) ? 2047 : (s < -2048) ? -2048 : s;
        e.due = edge_idx + 2; e.mix = c; e.clipped = (c != s);
        exp_q.push_back(e);
      end
      exp_err = 0;
      if (cfg_valid && m_rdy) begin
        if (cfg_ch >= 3'd2) exp_err = 1;
        else begin
          m_pend = 1; p_ch = int'(cfg_ch); p_mode = int'(cfg_mode); p_gain = int'(cfg_gain);
        end
      end
      exp_rdy = !m_pend;
      nco_n++;
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == edge_idx) begin
        check("mix_valid", mix_valid, 1);
        check("mix_out", longint'($signed(mix_out)), exp_q[0].mix);
        void'(exp_q.pop_front());
      end else begin
        check("mix_valid_idle", mix_valid, 0);
      end
      if (mix_valid) obs_q.push_back(int'($signed(mix_out)));
      check("fre_word", fre_word, exp_fre);
      check("clip_cnt", clip_cnt, exp_clip);
      check("cfg_ready", cfg_ready, exp_rdy);
      check("cfg_err", cfg_err, exp_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic send(input int x0, input int x1, input int fm);
    sample_valid = 1'b1;
    audio_in = {12'(x1), 12'(x0)};
    fm_sig = 12'(fm);
    tick(1);
    sample_valid = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int mode, input int gain);
    for (int i = 0; i < 50 && !cfg_ready; i++) tick(1);
    check("cfg_ready_wait", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_ch = 3'(ch); cfg_mode = 2'(mode); cfg_gain = 8'(gain);
    tick(1);
    cfg_valid = 1'b0;
    send(0, 0, 0);
    tick(4);
  endtask

  function automatic void pop_check(input string name, input int exp);
    int got;
    got = (obs_q.size() > 0) ? obs_q.pop_front() : 99999;
    check(name, got, exp);
  endfunction

  typedef struct { int m0; int g0; int m1; int g1; int x0; int x1; int mix; int clip; } mix_vec_t;
  typedef struct { int fm; bit en; longint fre; } fm_vec_t;
  mix_vec_t mv[13];
  fm_vec_t  fv[6];

  initial begin
    int pos, neg;
    longint prev_fre;
    mv[0]  = '{1, 128, 1, 128,   100,   200,   300, 0};
    mv[1]  = '{1, 128, 1, 128,  2000,  2000,  2047, 1};
    mv[2]  = '{1, 128, 1, 128, -2048, -2048, -2048, 2};
    mv[3]  = '{1,  64, 0, 128,   100,   555,    50, 2};
    mv[4]  = '{1,  64, 0, 128,  -101,     7,   -51, 2};
    mv[5]  = '{2, 128, 0, 128, -2048,     0,  2047, 3};
    mv[6]  = '{2, 128, 1, 128,   500,   200,  -300, 3};
    mv[7]  = '{1, 255, 1, 255,  2047,  2047,  2047, 4};
    mv[8]  = '{2, 255, 2, 255,  2047,  2047, -2048, 5};
    mv[9]  = '{1,   0, 0, 128,  1234,    99,     0, 5};
    mv[10] = '{2, 255, 0,   0, -2048,   -77,  2047, 6};
    mv[11] = '{1, 255, 0, 128, -2048,    33, -2048, 7};
    mv[12] = '{1,   1, 1,   1,    -1,     1,    -1, 7};
    fv[0] = '{-1,    1'b1, 416601341};
    fv[1] = '{2047,  1'b1, 438076669};
    fv[2] = '{-1,    1'b0, 416611827};
    fv[3] = '{-2048, 1'b1, 395136499};
    fv[4] = '{0,     1'b1, 416611827};
    fv[5] = '{5,     1'b1, 416664257};

    // Reset values
    RST = 1'b1;
    tick(2);
    mon_en = 1'b1;
    check("rst_mix_out", mix_out, 0);
    check("rst_mix_valid", mix_valid, 0);
    check("rst_fre_word", fre_word, CARRIER);
    check("rst_clip_cnt", clip_cnt, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_cfg_err", cfg_err, 0);
    RST = 1'b0;
    tick(2);

    // First sample: single strobe exactly 3 cycles after sample_valid
    send(100, 200, 0);
    check("lat_c1", mix_valid, 0);
    tick(1);
    check("lat_c2", mix_valid, 0);
    tick(1);
    check("lat_c3_valid", mix_valid, 1);
    check("lat_c3_mix", longint'($signed(mix_out)), 300);
    check("lat_c3_clip", clip_cnt, 0);
    tick(1);
    check("lat_c4", mix_valid, 0);
    tick(3);

    // Mode/gain/saturation table
    for (int i = 0; i < 13; i++) begin
      cfg_write(0, mv[i].m0, mv[i].g0);
      cfg_write(1, mv[i].m1, mv[i].g1);
      obs_q.delete();
      send(mv[i].x0, mv[i].x1, 0);
      tick(5);
      pop_check($sformatf("tbl%0d_mix", i), mv[i].mix);
      check($sformatf("tbl%0d_clip", i), clip_cnt, mv[i].clip);
    end

    // FM frequency word table: held one cycle after the sample, updated the next
    for (int i = 0; i < 6; i++) begin
      prev_fre = longint'(fre_word);
      fm_en = fv[i].en;
      send(0, 0, fv[i].fm);
      check($sformatf("fm%0d_hold", i), fre_word, prev_fre);
      tick(1);
      check($sformatf("fm%0d_fre", i), fre_word, fv[i].fre);
      tick(3);
    end
    fm_en = 1'b1;

    // Config accepted together with a sample applies from the next sample
    cfg_write(0, 1, 128);
    cfg_write(1, 0, 128);
    obs_q.delete();
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_mode = 2'd2; cfg_gain = 8'd128;
    sample_valid = 1'b1; audio_in = {12'd0, 12'd100};
    tick(1);
    cfg_valid = 1'b0;
    check("cfg_pending_ready", cfg_ready, 0);
    tick(2);
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
    check("cfg_commit_ready", cfg_ready, 1);
    tick(5);
    pop_check("cfg_old_mode", 100);
    pop_check("cfg_new_mode", -100);

    // Bad channel: error pulse, no state change
    cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_mode = 2'd0; cfg_gain = 8'd0;
    tick(1);
    cfg_valid = 1'b0;
    check("bad_ch_err", cfg_err, 1);
    check("bad_ch_ready", cfg_ready, 1);
    tick(1);
    check("bad_ch_err_pulse", cfg_err, 0);
    obs_q.delete();
    send(100, 0, 0);
    tick(5);
    pop_check("bad_ch_nochange", -100);

    // Reset with two samples in flight
    obs_q.delete();
    sample_valid = 1'b1; audio_in = {12'd0, 12'd2000}; fm_sig = 12'd5;
    tick(2);
    sample_valid = 1'b0;
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    check("midrst_mix_out", mix_out, 0);
    check("midrst_fre", fre_word, CARRIER);
    check("midrst_clip", clip_cnt, 0);
    check("midrst_ready", cfg_ready, 1);
    tick(6);
    check("midrst_no_valid", obs_q.size(), 0);
    send(100, 200, 0);
    tick(5);
    pop_check("midrst_defaults", 300);

    // clip_clr coinciding with a saturating S3 sample
    send(2000, 2000, 0);
    tick(1);
    clip_clr = 1'b1;
    tick(1);
    clip_clr = 1'b0;
    check("clr_win_valid", mix_valid, 1);
    check("clr_win_mix", longint'($signed(mix_out)), 2047);
    check("clr_win_cnt", clip_cnt, 0);
    tick(3);

    // DSB: sign follows the free-running subcarrier MSB
    cfg_write(0, 3, 128);
    cfg_write(1, 0, 128);
    obs_q.delete();
    sample_valid = 1'b1; audio_in = {12'd0, 12'd1000};
    tick(5200);
    sample_valid = 1'b0;
    tick(5);
    pos = 0; neg = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i] == 1000) pos++;
      if (obs_q[i] == -1000) neg++;
    end
    check("dsb_pos_half", pos >= 2400, 1);
    check("dsb_neg_half", neg >= 2400, 1);
    check("dsb_count", pos + neg, 5200);

    // Randomized run; the monitor compares everything against the model
    for (int i = 0; i < 3000; i++) begin
      sample_valid = ($urandom_range(0, 9) < 7);
      audio_in = 24'($urandom);
      fm_sig = 12'($urandom);
      if ($urandom_range(0, 19) == 0) fm_en = ~fm_en;
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_ch = 3'($urandom_range(0, 3));
      cfg_mode = 2'($urandom);
      cfg_gain = 8'($urandom);
      clip_clr = ($urandom_range(0, 49) == 0);
      tick(1);
    end
    sample_valid = 1'b0; cfg_valid = 1'b0; clip_clr = 1'b0;
    tick(6);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete by %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
